fp_add_normalizer: RTL and testbench
====================================

// Module: fp_add_normalizer
// PURPOSE
//  Post-add stage of the FP adder datapath: consumes the complement-adder result,
//  restores magnitude/sign, normalises iteratively (1 bit/cycle), flags exceptions.
//  Sits between the mantissa complement adder and the pack/round stage.
//  valid/ready on both sides; one operation in flight.
// PARAMETERS
//  MANT_W  24  mantissa width incl. hidden bit (adder instanced at this width)
//  EXP_W   8   exponent width; EXP_MAX = 2**EXP_W-1
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         synchronous reset, active-high
//  in_valid      in   1         operand set valid
//  in_ready      out  1         stage can accept (state IDLE)
//  in_sign_a     in   1         sign of operand A (larger-exponent operand)
//  in_eff_sub    in   1         effective subtraction (sign1 ^ sign2)
//  in_exp        in   EXP_W     common (larger) exponent from alignment
//  in_result     in   MANT_W    adder sum
//  in_carry      in   1         adder carry-out
//  in_shift_flag in   1         adder overflow on effective add
//  out_valid     out  1         result valid
//  out_ready     in   1         downstream accepts
//  out_sign      out  1         result sign
//  out_exp       out  EXP_W     result exponent
//  out_mant      out  MANT_W-1  fraction, hidden bit dropped
//  out_zero/out_overflow/out_underflow  out  1 each  exception flags
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; all data outputs and flags 0.
//    rst mid-operation discards the operation; no output produced.
//  - FSM IDLE->(accept)->NORM|DONE; NORM->DONE; DONE->(out_ready)->IDLE.
//  - Accept = in_valid & in_ready. Accept cycle registers:
//    mag  = (eff_sub & ~carry) ? (~result+1) : result   (MANT_W bits)
//    sign = eff_sub ? ~carry : sign_a
//    shift_flag=1: mant={carry,result[MANT_W-1:1]}, exp=in_exp+1;
//      exp+1==EXP_MAX -> exp=EXP_MAX, mant=0, overflow=1 (saturate, inf). -> DONE
//    mag==0 -> zero=1, sign=0, exp=0, mant=0. -> DONE
//    mag[MSB]=1 -> DONE; else -> NORM.
//  - NORM, per cycle: mant<<=1 (LSB 0), exp-=1. Stop -> DONE when mant[MSB]=1
//    or exp==1. exp reaches 1 with MSB still 0 -> out_exp=0, underflow=1
//    (denormal, mant kept as shifted). in_exp<=1 on entry: no shift, same rule.
//  - Latency: out_valid 1 cycle after accept, +1 per leading-zero shift;
//    max MANT_W cycles.
//  - DONE: out_valid=1; all outputs held stable until out_ready=1;
//    then out_valid=0, in_ready=1 next cycle. in_ready=0 outside IDLE.
//  - Exponent arithmetic EXP_W bits, never wraps (bounded by rules above).
//  - in_exp==EXP_MAX on input: output EXP_MAX, overflow=1, mant=0.
// STRUCTURE
//  - fp_defs.vh: EXP_W, MANT_W, EXP_MAX, state encodings IDLE/NORM/DONE.
//  - One sub-module: fp_negate (MANT_W two's-complement negate, combinational).
//  - FSM, shift register and exponent counter in this module.
// TESTING (MANT_W=24, EXP_W=8)
//  1 add ovf: shift_flag=1,carry=1,result=24'h400000,exp=8'h80
//    -> exp 8'h81, mant 23'h200000, sign=sign_a, out_valid 1 cycle after accept.
//  2 negative: eff_sub=1,carry=0,result=24'hFF0000,exp=8'h80
//    -> sign 1, 7 shifts, exp 8'h79, mant 0, out_valid 8 cycles after accept.
//  3 cancel: eff_sub=1,carry=1,result=0 -> zero=1,sign=0,exp=0,mant=0, latency 1.
//  4 underflow: eff_sub=1,carry=1,result=24'h000100,exp=8'h03
//    -> 2 shifts, exp 0, mant 23'h000400, underflow=1.
//  5 sat: shift_flag=1,carry=1,exp=8'hFE -> exp 8'hFF, mant 0, overflow=1.
//  6 out_ready=0 for 5 cycles -> outputs stable, in_ready=0; rst in NORM
//    -> out_valid=0, outputs 0, in_ready=1 next cycle; next op correct.

Source files
------------

// File: rtl/fp_add_normalizer_pkg.sv
// fp_add_normalizer_pkg: shared widths and FSM state encoding for the post-add normaliser
package fp_add_normalizer_pkg;
   localparam int DEF_MANT_W = 24;
   localparam int DEF_EXP_W  = 8;
   localparam int DEF_EXP_MAX = (1 << DEF_EXP_W) - 1;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/fp_add_normalizer_negate.sv
// fp_add_normalizer_negate: combinational two's-complement negate of the adder sum
module fp_add_normalizer_negate #(
   parameter int W = 24
) (
   input  logic [W-1:0] i_a,
   output logic [W-1:0] o_neg
);
   assign o_neg = ~i_a + W'(1);
endmodule

// File: rtl/fp_add_normalizer.sv
// fp_add_normalizer: restores magnitude/sign of the adder result, normalises one bit
// per cycle and flags zero/overflow/underflow; one operation in flight.
module fp_add_normalizer
   import fp_add_normalizer_pkg::*;
#(
   parameter int MANT_W = DEF_MANT_W,
   parameter int EXP_W  = DEF_EXP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign_a,
   input  logic              in_eff_sub,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W-1:0] in_result,
   input  logic              in_carry,
   input  logic              in_shift_flag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sign,
   output logic [EXP_W-1:0]  out_exp,
   output logic [MANT_W-2:0] out_mant,
   output logic              out_zero,
   output logic              out_overflow,
   output logic              out_underflow
);
   localparam logic [EXP_W-1:0] L_EXP_MAX = '1;
   localparam logic [EXP_W-1:0] L_EXP_ONE = EXP_W'(1);

   state_t            r_state;
   logic [MANT_W-1:0] r_mant;
   logic [EXP_W-1:0]  r_exp;
   logic              r_sign, r_zero, r_ovf, r_unf;
   logic [MANT_W-1:0] w_neg, w_mag, w_sh;
   logic [EXP_W-1:0]  w_exp_inc, w_exp_dec;
   logic              w_sign, w_stop_unf;

   fp_add_normalizer_negate #(.W(MANT_W)) u_negate (
      .i_a   (in_result),
      .o_neg (w_neg)
   );

   always_comb begin
      w_mag      = (in_eff_sub && !in_carry) ? w_neg : in_result;
      w_sign     = in_eff_sub ? !in_carry : in_sign_a;
      w_exp_inc  = in_exp + L_EXP_ONE;
      w_exp_dec  = r_exp - L_EXP_ONE;
      w_sh       = {r_mant[MANT_W-2:0], 1'b0};
      w_stop_unf = !w_sh[MANT_W-1] && (w_exp_dec == L_EXP_ONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_mant  <= '0;
         r_exp   <= '0;
         r_sign  <= 1'b0;
         r_zero  <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (in_valid) begin
               r_sign  <= w_sign;
               r_zero  <= 1'b0;
               r_ovf   <= 1'b0;
               r_unf   <= 1'b0;
               r_state <= ST_DONE;
               if (in_exp == L_EXP_MAX || (in_shift_flag && w_exp_inc == L_EXP_MAX)) begin
                  r_exp  <= L_EXP_MAX;
                  r_mant <= '0;
                  r_ovf  <= 1'b1;
               end else if (in_shift_flag) begin
                  r_exp  <= w_exp_inc;
                  r_mant <= {in_carry, in_result[MANT_W-1:1]};
               end else if (w_mag == '0) begin
                  r_exp  <= '0;
                  r_mant <= '0;
                  r_sign <= 1'b0;
                  r_zero <= 1'b1;
               end else begin
                  r_mant <= w_mag;
                  // leading zero with no exponent headroom left: denormal, no shifting
                  if (!w_mag[MANT_W-1] && in_exp <= L_EXP_ONE) begin
                     r_exp <= '0;
                     r_unf <= 1'b1;
                  end else begin
                     r_exp <= in_exp;
                     if (!w_mag[MANT_W-1]) r_state <= ST_NORM;
                  end
               end
            end
            ST_NORM: begin
               r_mant <= w_sh;
               r_exp  <= w_stop_unf ? '0 : w_exp_dec;
               r_unf  <= w_stop_unf;
               if (w_sh[MANT_W-1] || w_exp_dec == L_EXP_ONE) r_state <= ST_DONE;
            end
            ST_DONE: if (out_ready) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready      = (r_state == ST_IDLE);
   assign out_valid     = (r_state == ST_DONE);
   assign out_sign      = r_sign;
   assign out_exp       = r_exp;
   assign out_mant      = r_mant[MANT_W-2:0];
   assign out_zero      = r_zero;
   assign out_overflow  = r_ovf;
   assign out_underflow = r_unf;
endmodule

// File: tb/tb_fp_add_normalizer.sv
// tb_fp_add_normalizer: random and directed operations checked against a
// leading-zero-count model of the normaliser, every valid cycle.
module tb_fp_add_normalizer;
   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
      logic        zero, ovf, unf;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 0, rst = 1;
   logic        in_valid = 0, in_sign_a = 0, in_eff_sub = 0, in_carry = 0, in_shift_flag = 0;
   logic [7:0]  in_exp = 0;
   logic [23:0] in_result = 0;
   logic        out_ready = 0;
   logic        in_ready, out_valid, out_sign, out_zero, out_overflow, out_underflow;
   logic [7:0]  out_exp;
   logic [22:0] out_mant;

   int   n_cmp = 0, n_fail = 0, cyc = 0;
   exp_t q[$];
   exp_t e;
   bit   seen = 0;

   fp_add_normalizer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign_a(in_sign_a), .in_eff_sub(in_eff_sub), .in_exp(in_exp),
      .in_result(in_result), .in_carry(in_carry), .in_shift_flag(in_shift_flag),
      .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
      .out_exp(out_exp), .out_mant(out_mant), .out_zero(out_zero),
      .out_overflow(out_overflow), .out_underflow(out_underflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
      end
   endtask

   task automatic tmo(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out", nm);
   endtask

   // Normalised value = magnitude shifted left by its leading zeros, limited so the
   // exponent never goes below 1; a still-unnormalised result is a denormal.
   function automatic exp_t model(input logic sa, es, input logic [7:0] ex,
                                  input logic [23:0] r, input logic c, sf);
      exp_t x;
      logic [23:0] mag, full;
      int lz, sh, room;
      x = '{default: 0};
      x.lat = 1;
      mag = (es && !c) ? 24'((32'd1 << 24) - {8'd0, r}) : r;
      x.sign = es ? !c : sa;
      if (ex == 8'd255 || (sf && int'(ex) + 1 == 255)) begin
         x.exp = 8'd255;
         x.ovf = 1;
      end else if (sf) begin
         x.exp = ex + 8'd1;
         x.mant = r[23:1];
      end else if (mag == 0) begin
         x.sign = 0;
         x.zero = 1;
      end else begin
         lz = 0;
         while (!mag[23 - lz]) lz++;
         room = int'(ex) - 1;
         if (room < 0) room = 0;
         sh = (lz < room) ? lz : room;
         full = mag << sh;
         x.mant = full[22:0];
         x.exp = full[23] ? 8'(int'(ex) - sh) : 8'd0;
         x.unf = !full[23];
         x.lat = 1 + sh;
      end
      return x;
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) chk("spurious_valid", 32'(out_valid), 0);
         else begin
            e = q[0];
            chk("sign", 32'(out_sign), 32'(e.sign));
            chk("exp", 32'(out_exp), 32'(e.exp));
            chk("mant", 32'(out_mant), 32'(e.mant));
            chk("zero", 32'(out_zero), 32'(e.zero));
            chk("overflow", 32'(out_overflow), 32'(e.ovf));
            chk("underflow", 32'(out_underflow), 32'(e.unf));
            chk("in_ready_busy", 32'(in_ready), 0);
            if (!seen) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            seen = 1;
            if (out_ready) begin
               void'(q.pop_front());
               seen = 0;
            end
         end
      end
   end

   task automatic do_reset();
      q.delete();
      seen = 0;
      in_valid = 0;
      out_ready = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic drive(input logic sa, es, input logic [7:0] ex, input logic [23:0] r,
                        input logic c, sf);
      exp_t x;
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk) #1;
         n++;
      end
      if (!in_ready) tmo("in_ready_wait");
      {in_sign_a, in_eff_sub, in_exp, in_result, in_carry, in_shift_flag} = {sa, es, ex, r, c, sf};
      in_valid = 1;
      x = model(sa, es, ex, r, c, sf);
      x.acc = cyc;
      q.push_back(x);
      @(posedge clk) #1;
      in_valid = 0;
      in_exp = 8'($urandom);
      in_result = 24'($urandom);
   endtask

   task automatic run_op(input logic sa, es, input logic [7:0] ex, input logic [23:0] r,
                         input logic c, sf, input int stall);
      int n = 0;
      drive(sa, es, ex, r, c, sf);
      while (!out_valid && n < 40) begin
         @(posedge clk) #1;
         n++;
      end
      if (!out_valid) begin
         tmo("out_valid_wait");
         do_reset();
         return;
      end
      repeat (stall) @(posedge clk) #1;
      out_ready = 1;
      @(posedge clk) #1;
      out_ready = 0;
      chk("in_ready_after_hs", 32'(in_ready), 1);
      chk("out_valid_after_hs", 32'(out_valid), 0);
   endtask

   initial begin
      exp_t m;
      logic sa, es, c, sf;
      logic [7:0] ex;
      logic [23:0] r;
      m = model(0, 0, 8'h80, 24'h400000, 1, 1);
      chk("pin1_exp", 32'(m.exp), 32'h81);
      chk("pin1_mant", 32'(m.mant), 32'h200000);
      m = model(0, 1, 8'h80, 24'hFF0000, 0, 0);
      chk("pin2_sign", 32'(m.sign), 1);
      chk("pin2_exp", 32'(m.exp), 32'h79);
      chk("pin2_lat", 32'(m.lat), 8);
      m = model(0, 1, 8'h03, 24'h000100, 1, 0);
      chk("pin4_mant", 32'(m.mant), 32'h000400);
      chk("pin4_unf", {m.unf, m.exp}, 32'h100);
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_outputs", {out_sign, out_exp, out_mant, out_zero, out_overflow, out_underflow}, 0);
      run_op(1, 0, 8'h80, 24'h400000, 1, 1, 0);
      run_op(0, 1, 8'h80, 24'hFF0000, 0, 0, 1);
      run_op(1, 1, 8'h40, 24'h000000, 1, 0, 0);
      run_op(0, 1, 8'h03, 24'h000100, 1, 0, 2);
      run_op(0, 0, 8'hFE, 24'h123456, 1, 1, 0);
      run_op(1, 0, 8'hFF, 24'h800000, 0, 0, 0);
      run_op(0, 0, 8'h01, 24'h000001, 0, 0, 0);
      run_op(0, 0, 8'h02, 24'h400000, 0, 0, 0);
      run_op(0, 1, 8'h80, 24'hFF0000, 0, 0, 5);
      drive(0, 1, 8'h80, 24'hFF0000, 0, 0);
      repeat (2) @(posedge clk) #1;
      q.delete();
      seen = 0;
      rst = 1;
      @(posedge clk) #1;
      rst = 0;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_outputs", {out_sign, out_exp, out_mant, out_zero, out_overflow, out_underflow}, 0);
      run_op(0, 0, 8'h80, 24'h400000, 1, 1, 0);
      for (int i = 0; i < 300; i++) begin
         sa = 1'($urandom);
         es = 1'($urandom);
         c = 1'($urandom);
         sf = !es && ($urandom_range(0, 3) == 0);
         if (sf) c = 1;
         case ($urandom_range(0, 9))
            0: ex = 8'($urandom_range(0, 5));
            1: ex = 8'($urandom_range(250, 255));
            default: ex = 8'($urandom);
         endcase
         r = 24'($urandom) >> $urandom_range(0, 24);
         run_op(sa, es, ex, r, c, sf, $urandom_range(0, 3));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
